// File: rtl/riio_gpi_ctrl.sv
// Per-pad input-enable/Schmitt sequencing, debounce, edge pulses and interrupts for pulled-up GPI pads.
// Optional IRQ logic is built only when RIIO_GPI_CTRL_IRQ_EN is defined; otherwise IRQ outputs are tied 0.
module riio_gpi_ctrl #(
  parameter int N_PADS     = 4,
  parameter int DEB_W      = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic [N_PADS-1:0]     EN_I,
  input  logic [2*N_PADS-1:0]   STE_CFG_I,
  input  logic [DEB_W-1:0]      DEB_LIMIT_I,
  input  logic [N_PADS-1:0]     PAD_DI_I,
  input  logic [N_PADS-1:0]     IRQ_RISE_EN_I,
  input  logic [N_PADS-1:0]     IRQ_FALL_EN_I,
  input  logic [N_PADS-1:0]     IRQ_MASK_I,
  input  logic [N_PADS-1:0]     IRQ_CLR_I,
  output logic [N_PADS-1:0]     PAD_IE_O,
  output logic [2*N_PADS-1:0]   PAD_STE_O,
  output logic [N_PADS-1:0]     LEVEL_O,
  output logic [N_PADS-1:0]     RISE_O,
  output logic [N_PADS-1:0]     FALL_O,
  output logic [N_PADS-1:0]     IRQ_STAT_O,
  output logic                  IRQ_O
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {OFF, ARM, ACTIVE} state_t;

  for (genvar n = 0; n < N_PADS; n++) begin : g_pad
    state_t           state, state_nxt;
    logic [1:0]       sync;
    logic             s;
    logic [SET_W-1:0] settle, settle_nxt;
    logic [DEB_W-1:0] deb, deb_nxt;
    logic             ie, ie_nxt;
    logic [1:0]       ste, ste_nxt;
    logic             level, level_nxt;
    logic             rise, rise_nxt;
    logic             fall, fall_nxt;

    assign s = sync[1];

    always_ff @(posedge CLK_I) begin
      if (RST_I) begin
        state  <= OFF;
        sync   <= '0;
        settle <= '0;
        deb    <= '0;
        ie     <= 1'b0;
        ste    <= '0;
        level  <= 1'b0;
        rise   <= 1'b0;
        fall   <= 1'b0;
      end else begin
        state  <= state_nxt;
        sync   <= {sync[0], PAD_DI_I[n]};
        settle <= settle_nxt;
        deb    <= deb_nxt;
        ie     <= ie_nxt;
        ste    <= ste_nxt;
        level  <= level_nxt;
        rise   <= rise_nxt;
        fall   <= fall_nxt;
      end
    end

    always_comb begin
      state_nxt  = state;
      settle_nxt = settle;
      deb_nxt    = deb;
      ie_nxt     = ie;
      ste_nxt    = ste;
      level_nxt  = level;
      rise_nxt   = 1'b0;
      fall_nxt   = 1'b0;
      // Disable wins from any state; Schmitt config is deliberately kept.
      if (!EN_I[n]) begin
        state_nxt  = OFF;
        settle_nxt = '0;
        deb_nxt    = '0;
        ie_nxt     = 1'b0;
        level_nxt  = 1'b0;
      end else begin
        case (state)
          OFF: begin
            state_nxt  = ARM;
            ie_nxt     = 1'b1;
            ste_nxt    = STE_CFG_I[2*n +: 2];
            settle_nxt = '0;
            deb_nxt    = '0;
          end
          ARM: begin
            if (settle == SETTLE_LAST) begin
              state_nxt = ACTIVE;
              level_nxt = s;
              deb_nxt   = '0;
            end else begin
              settle_nxt = settle + 1'b1;
            end
          end
          ACTIVE: begin
            // >= so a limit lowered mid-count takes effect on the next differing cycle.
            if (s != level) begin
              if (deb >= DEB_LIMIT_I) begin
                level_nxt = s;
                deb_nxt   = '0;
                rise_nxt  = s;
                fall_nxt  = ~s;
              end else begin
                deb_nxt = deb + 1'b1;
              end
            end else begin
              deb_nxt = '0;
            end
          end
          default: state_nxt = OFF;
        endcase
      end
    end

    assign PAD_IE_O[n]         = ie;
    assign PAD_STE_O[2*n +: 2] = ste;
    assign LEVEL_O[n]          = level;
    assign RISE_O[n]           = rise;
    assign FALL_O[n]           = fall;
  end

`ifdef RIIO_GPI_CTRL_IRQ_EN
  logic [N_PADS-1:0] stat;
  logic              irq;

  // Set takes priority over a coincident clear.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      stat <= '0;
      irq  <= 1'b0;
    end else begin
      stat <= (stat & ~IRQ_CLR_I) | (RISE_O & IRQ_RISE_EN_I) | (FALL_O & IRQ_FALL_EN_I);
      irq  <= |(stat & IRQ_MASK_I);
    end
  end

  assign IRQ_STAT_O = stat;
  assign IRQ_O      = irq;
`else
  logic unused_irq_in;
  assign unused_irq_in = ^{IRQ_RISE_EN_I, IRQ_FALL_EN_I, IRQ_MASK_I, IRQ_CLR_I};
  assign IRQ_STAT_O    = '0;
  assign IRQ_O         = 1'b0;
`endif

endmodule

// File: doc/riio_gpi_ctrl.md
# riio_gpi_ctrl

Per-pad controller for a bank of pulled-up general-purpose input pads in the EG1D80V IO ring. It owns each pad's input-enable and Schmitt-trigger configuration and sequences a settle interval after enable. It synchronises and debounces the pad receiver output, then reports clean levels, edge pulses and maskable interrupts to core logic.

## Interface
- `N_PADS`, default 4: number of pads controlled.
- `DEB_W`, default 8: debounce counter width.
- `SETTLE_CYC`, default 4: cycles in ARM before input is trusted; must be ≥1.
- `CLK_I` in 1: core clock.
- `RST_I` in 1: reset, synchronous, active-high.
- `EN_I` in N_PADS: per-pad enable, level.
- `STE_CFG_I` in 2*N_PADS: per-pad Schmitt config; pad n uses bits [2n+1:2n].
- `DEB_LIMIT_I` in DEB_W: debounce limit L, shared by all pads, quasi-static.
- `PAD_DI_I` in N_PADS: pad receiver output, bit 0 of the pad's `DI_O`, asynchronous.
- `IRQ_RISE_EN_I` / `IRQ_FALL_EN_I` in N_PADS: per-pad edge interrupt enables.
- `IRQ_MASK_I` in N_PADS: per-pad interrupt output mask (1 = pass).
- `IRQ_CLR_I` in N_PADS: per-pad status clear pulse.
- `PAD_IE_O` out N_PADS: to pad `IE_I`.
- `PAD_STE_O` out 2*N_PADS: to pad `STE_I`.
- `LEVEL_O` out N_PADS: debounced pad level.
- `RISE_O` / `FALL_O` out N_PADS: one-cycle edge pulses.
- `IRQ_STAT_O` out N_PADS: sticky interrupt status.
- `IRQ_O` out 1: registered interrupt request.

## Operation
- All outputs are 0 after reset. All internal counters and synchroniser flops are 0 after reset. Each pad FSM is in OFF.
- Each pad has an FSM with states OFF, ARM and ACTIVE.
- OFF: `PAD_IE_O`=0, `LEVEL_O`=0, counters cleared. When `EN_I[n]`=1, go to ARM.
- OFF→ARM edge: `PAD_IE_O[n]`←1, `PAD_STE_O` pair←`STE_CFG_I` pair, settle counter←0.
- `STE_CFG_I` is sampled only on the OFF→ARM edge. Later changes have no effect until the pad is re-enabled.
- ARM: settle counter increments each cycle. When it reaches SETTLE_CYC-1, go to ACTIVE.
- ARM→ACTIVE edge: `LEVEL_O[n]`←synchronised input, with no edge pulse. The debounce counter is cleared.
- ACTIVE, per cycle, where s = synchronised input:
  - If s ≠ `LEVEL_O`: if counter = L, then `LEVEL_O`←s, counter←0, and pulse `RISE_O` or `FALL_O`; otherwise counter+1.
  - If s = `LEVEL_O`: counter←0.
- The counter never exceeds L. With L=0, the level follows s with one register stage.
- `EN_I[n]`=0 in any state: go to OFF on the next edge. This clears IE, level and counters, generates no `FALL_O` pulse and keeps `PAD_STE_O`.
- Synchroniser: two flops per pad, running in all states.
- IRQ (see Configuration):
  - `IRQ_STAT_O[n]` is set by `RISE_O[n]`&`IRQ_RISE_EN_I[n]` or `FALL_O[n]`&`IRQ_FALL_EN_I[n]`.
  - It is cleared by `IRQ_CLR_I[n]`. If set and clear occur in the same cycle, set wins.
  - `IRQ_O` ← |(`IRQ_STAT_O` & `IRQ_MASK_I`), registered.
- Pads are fully independent. No arbitration between pads.

## Timing
- `EN_I` rise at edge k: `PAD_IE_O`=1 after edge k+1. ACTIVE and `LEVEL_O` are valid after edge k+1+SETTLE_CYC.
- Pad change settled before edge t in ACTIVE, held stable: s changes after edge t+1. `LEVEL_O` and the edge pulse change after edge t+2+L.
- Glitch on s shorter than L+1 cycles: no level change, counter returns to 0.
- `RISE_O`/`FALL_O`: high exactly one cycle, aligned with the `LEVEL_O` change.
- `IRQ_STAT_O` sets one cycle after the pulse. `IRQ_O` follows one cycle later.
- `RST_I` mid-operation: all state returns to reset values on that edge. Pulses in flight are dropped.
- Changing L while a count is in progress: the new L applies immediately. If counter ≥ new L, the level updates on the next differing cycle.

## Configuration
- `RIIO_GPI_CTRL_IRQ_EN` defined: IRQ status, clear and `IRQ_O` logic as specified.
- `RIIO_GPI_CTRL_IRQ_EN` undefined: `IRQ_STAT_O` and `IRQ_O` are tied 0. IRQ inputs are ignored. Ports remain present.

## Test plan
- Reset then `EN_I[0]`=1 with `STE_CFG_I`=2'b10, SETTLE_CYC=4 → `PAD_IE_O[0]`=1 one cycle later; `PAD_STE_O[1:0]`=2'b10; ACTIVE after 5 cycles; no edge pulse.
- L=3, ACTIVE, `PAD_DI_I[1]` 0→1 held → `LEVEL_O[1]`=1 and one-cycle `RISE_O[1]` 5 cycles after the change.
- L=3, a 3-cycle high glitch followed by return to 0 → `LEVEL_O` stays 0, no pulse.
- `IRQ_FALL_EN_I[2]`=1, mask=1, falling edge → `IRQ_STAT_O[2]`=1 next cycle, `IRQ_O`=1 one cycle later. `IRQ_CLR_I[2]` in the same cycle as a new fall → status stays 1.
- Disable pad while `LEVEL_O`=1 → OFF next edge, `LEVEL_O`=0, no `FALL_O`. `STE_CFG_I` change while ACTIVE → `PAD_STE_O` unchanged until re-enable.
- Assert `RST_I` mid-debounce → all outputs 0 on the next edge. Build without `RIIO_GPI_CTRL_IRQ_EN` → `IRQ_O` stays 0 across edges.
